riscv_checkpoint_monitor: RTL and testbench
===========================================

Name: riscv_checkpoint_monitor

Overview:
- Synthesizable, parametrised successor to the RISCV bench pass/fail checker; sits beside RISCV_TOP and watches NUM_INST, OUTPUT_PORT and HALT.
- Holds a loadable table of NUM_CHK checkpoints, each an instruction count plus an expected OUTPUT_PORT value, and checks them strictly in order.
- Reports pass, fail or timeout with a cycle count and fail details, so the same checking runs on FPGA as well as in simulation.

Parameters:
NUM_CHK, 17, number of checkpoint table entries
IDX_W, 5, index width; must satisfy 2^IDX_W > NUM_CHK
DWIDTH, 32, width of NUM_INST, OUTPUT_PORT and table fields
CWIDTH, 32, cycle counter width
TIMEOUT, 100000, RUN cycles before timeout; 0 disables timeout

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
LOAD_EN  in  1  write table entry this cycle (IDLE only)
LOAD_IDX  in  IDX_W  entry index
LOAD_INST  in  DWIDTH  checkpoint instruction count
LOAD_ANS  in  DWIDTH  expected OUTPUT_PORT
START  in  1  leave IDLE and begin RUN
NUM_INST  in  DWIDTH  retired instruction count from core
OUTPUT_PORT  in  DWIDTH  core output value
HALT  in  1  core halt
DONE  out  1  in PASS, FAIL or TOUT
PASS  out  1  all checkpoints matched and HALT seen
FAIL_CODE  out  2  0 none, 1 mismatch, 2 skipped, 3 missing at halt
FAIL_IDX  out  IDX_W  failing entry
FAIL_GOT  out  DWIDTH  OUTPUT_PORT captured at the failure
FAIL_EXP  out  DWIDTH  expected value of the failing entry
CHK_CNT  out  IDX_W  checkpoints passed so far
CYCLE  out  CWIDTH  RUN cycles elapsed

Behaviour:
- Reset: state IDLE; all outputs 0; pointer 0; table contents not cleared.
- Clock and reset: one clock CLK; reset RST is asynchronous and active-high.
- States: IDLE, RUN, PASS, FAIL, TOUT. PASS, FAIL and TOUT are terminal; only RST leaves them.
- IDLE:
  - LOAD_EN writes the entry at LOAD_IDX; LOAD_IDX >= NUM_CHK is ignored.
  - START moves to RUN next cycle and clears CYCLE, CHK_CNT and the pointer.
  - START with LOAD_EN in the same cycle: the write is performed, then the state moves to RUN.
- Table rule: entries are in ascending LOAD_INST order; ordering is not checked in hardware.
- RUN, every cycle, with p = pointer:
  - CYCLE increments; it saturates at all-ones.
  - If p < NUM_CHK and NUM_INST == inst[p]:
    - OUTPUT_PORT == ans[p]: p and CHK_CNT increment next cycle.
    - Otherwise: go to FAIL, code 1.
  - Else if p < NUM_CHK and NUM_INST > inst[p]: go to FAIL, code 2 (checkpoint skipped).
  - HALT is evaluated after the checkpoint compare in the same cycle:
    - A match that completes the table counts, so PASS is allowed in that cycle.
    - A failure in the same cycle takes priority over HALT.
    - HALT with all entries passed: PASS. HALT with entries remaining: FAIL, code 3.
  - If TIMEOUT != 0 and CYCLE == TIMEOUT-1 with no other event: go to TOUT. Any other event in that cycle takes priority.
- Fail capture: FAIL_IDX = p, FAIL_GOT = OUTPUT_PORT, FAIL_EXP = ans[p], all registered in the transition cycle and held.
- Output timing: all outputs are registered, so state outputs appear one cycle after the triggering input. DONE = state is PASS, FAIL or TOUT.
- RST asserted mid-RUN aborts immediately and returns to IDLE; the table is retained.
- NUM_INST equal to an entry for several consecutive cycles is checked only once, because the pointer has already advanced.

Optional Feature:
- Macro CHK_MASK_EN.
- Defined:
  - Adds input LOAD_MASK [DWIDTH-1:0] and stores one mask per entry.
  - Compare becomes (OUTPUT_PORT & mask) == (ans & mask).
  - FAIL_GOT still captures the unmasked value.
- Undefined: no port, no storage, full-width compare.

Test Plan:
- Load 3 entries (4, 0x0eec), (6, 0x0000), (8, 0x0001); START; drive matching NUM_INST/OUTPUT_PORT, then HALT at NUM_INST 10 -> PASS=1, DONE=1, CHK_CNT=3, FAIL_CODE=0.
- Same table; at NUM_INST=6 drive OUTPUT_PORT=0x0005 -> FAIL_CODE=1, FAIL_IDX=1, FAIL_GOT=0x5, FAIL_EXP=0x0, PASS=0.
- Same table; NUM_INST jumps 4 -> 7 -> FAIL_CODE=2, FAIL_IDX=1.
- Same table; HALT at NUM_INST 8 together with a matching entry 2 -> PASS=1. HALT at NUM_INST 6 (entry 1 matches, entry 2 pending) -> FAIL_CODE=3, FAIL_IDX=2.
- TIMEOUT=20, NUM_INST held at 0 -> DONE=1, PASS=0, FAIL_CODE=0, state TOUT after 20 RUN cycles, CYCLE=19. Assert RST mid-RUN -> all outputs 0 the same cycle.
- CHK_MASK_EN defined, mask 0x00FF, ans 0x12AB, OUTPUT_PORT 0x99AB -> match; without the macro -> FAIL_CODE=1.

Source files
------------

// File: rtl/riscv_checkpoint_monitor.sv
// riscv_checkpoint_monitor
//   Watches a RISC-V core's retired-instruction count, output port and halt
//   flag, and checks them against a loadable table of checkpoints. Each
//   checkpoint is an instruction count plus the OUTPUT_PORT value expected
//   at that count. Checkpoints are checked strictly in table order.
//   The result is reported as pass, fail or timeout, together with a cycle
//   count and details of the failure.
//
//   Optional build macro CHK_MASK_EN: adds a per-entry compare mask
//   (LOAD_MASK input). When it is not defined, the full width is compared.
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   LOAD_EN/IDX/INST/ANS  table write port, honoured in IDLE only
//   LOAD_MASK         per-entry compare mask (CHK_MASK_EN builds only)
//   START             leave IDLE and begin RUN
//   NUM_INST, OUTPUT_PORT, HALT  observed core signals
//   DONE, PASS        terminal-state flags
//   FAIL_CODE         0 none, 1 mismatch, 2 skipped, 3 missing at halt
//   FAIL_IDX/GOT/EXP  failing entry, captured OUTPUT_PORT, expected value
//   CHK_CNT           checkpoints passed so far
//   CYCLE             RUN cycles elapsed (saturating)
module riscv_checkpoint_monitor #(
  parameter int NUM_CHK = 17,
  parameter int IDX_W   = 5,
  parameter int DWIDTH  = 32,
  parameter int CWIDTH  = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD_EN,
  input  logic [IDX_W-1:0]  LOAD_IDX,
  input  logic [DWIDTH-1:0] LOAD_INST,
  input  logic [DWIDTH-1:0] LOAD_ANS,
`ifdef CHK_MASK_EN
  input  logic [DWIDTH-1:0] LOAD_MASK,
`endif
  input  logic              START,
  input  logic [DWIDTH-1:0] NUM_INST,
  input  logic [DWIDTH-1:0] OUTPUT_PORT,
  input  logic              HALT,
  output logic              DONE,
  output logic              PASS,
  output logic [1:0]        FAIL_CODE,
  output logic [IDX_W-1:0]  FAIL_IDX,
  output logic [DWIDTH-1:0] FAIL_GOT,
  output logic [DWIDTH-1:0] FAIL_EXP,
  output logic [IDX_W-1:0]  CHK_CNT,
  output logic [CWIDTH-1:0] CYCLE
);

  localparam logic [IDX_W-1:0]  NUM_CHK_I = IDX_W'(NUM_CHK);
  localparam logic [CWIDTH-1:0] TOUT_LAST = CWIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CWIDTH-1:0] cycle_q, cycle_d;
  logic [1:0]        code_q, code_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic [DWIDTH-1:0] got_q, got_d;
  logic [DWIDTH-1:0] exp_q, exp_d;

  // Checkpoint table; deliberately not reset so it survives an aborted run.
  logic [DWIDTH-1:0] inst_mem [NUM_CHK];
  logic [DWIDTH-1:0] ans_mem  [NUM_CHK];
`ifdef CHK_MASK_EN
  logic [DWIDTH-1:0] mask_mem [NUM_CHK];
`endif

  always_ff @(posedge CLK) begin
    if (LOAD_EN && state_q == S_IDLE && LOAD_IDX < NUM_CHK_I) begin
      inst_mem[LOAD_IDX] <= LOAD_INST;
      ans_mem[LOAD_IDX]  <= LOAD_ANS;
`ifdef CHK_MASK_EN
      mask_mem[LOAD_IDX] <= LOAD_MASK;
`endif
    end
  end

  logic             ptr_valid, hit, skip, ans_ok;
  logic [IDX_W-1:0] cur_idx, ptr_adv, adv_idx;
  logic             fail_now;
  logic [1:0]       fcode;
  logic [IDX_W-1:0] fidx;
  logic [DWIDTH-1:0] fexp;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cycle_d  = cycle_q;
    code_d   = code_q;
    fidx_d   = fidx_q;
    got_d    = got_q;
    exp_d    = exp_q;
    fail_now = 1'b0;
    fcode    = 2'd0;
    fidx     = '0;
    fexp     = '0;

    ptr_valid = ptr_q < NUM_CHK_I;
    cur_idx   = ptr_valid ? ptr_q : '0;
    hit       = ptr_valid && (NUM_INST == inst_mem[cur_idx]);
    skip      = ptr_valid && (NUM_INST > inst_mem[cur_idx]);
`ifdef CHK_MASK_EN
    ans_ok    = (OUTPUT_PORT & mask_mem[cur_idx]) == (ans_mem[cur_idx] & mask_mem[cur_idx]);
`else
    ans_ok    = OUTPUT_PORT == ans_mem[cur_idx];
`endif
    // Pointer as it stands after this cycle's compare; HALT is judged on it
    // so a match that completes the table can pass in the same cycle.
    ptr_adv   = (hit && ans_ok) ? ptr_q + IDX_W'(1) : ptr_q;
    adv_idx   = (ptr_adv < NUM_CHK_I) ? ptr_adv : '0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_RUN;
          ptr_d   = '0;
          cycle_d = '0;
        end
      end
      S_RUN: begin
        ptr_d = ptr_adv;
        if (hit && !ans_ok) begin
          fail_now = 1'b1;
          fcode    = 2'd1;
          fidx     = ptr_q;
          fexp     = ans_mem[cur_idx];
        end else if (skip) begin
          fail_now = 1'b1;
          fcode    = 2'd2;
          fidx     = ptr_q;
          fexp     = ans_mem[cur_idx];
        end else if (HALT && ptr_adv != NUM_CHK_I) begin
          fail_now = 1'b1;
          fcode    = 2'd3;
          fidx     = ptr_adv;
          fexp     = ans_mem[adv_idx];
        end

        if (fail_now) begin
          state_d = S_FAIL;
          code_d  = fcode;
          fidx_d  = fidx;
          got_d   = OUTPUT_PORT;
          exp_d   = fexp;
        end else if (HALT) begin
          state_d = S_PASS;
        end else if (TIMEOUT != 0 && cycle_q == TOUT_LAST) begin
          state_d = S_TOUT;
        end

        // CYCLE freezes on the terminal transition, so TOUT reports TIMEOUT-1.
        if (state_d == S_RUN && cycle_q != '1) cycle_d = cycle_q + CWIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cycle_q <= '0;
      code_q  <= '0;
      fidx_q  <= '0;
      got_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cycle_q <= cycle_d;
      code_q  <= code_d;
      fidx_q  <= fidx_d;
      got_q   <= got_d;
      exp_q   <= exp_d;
    end
  end

  assign DONE      = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TOUT);
  assign PASS      = state_q == S_PASS;
  assign FAIL_CODE = code_q;
  assign FAIL_IDX  = fidx_q;
  assign FAIL_GOT  = got_q;
  assign FAIL_EXP  = exp_q;
  assign CHK_CNT   = ptr_q;
  assign CYCLE     = cycle_q;

endmodule

// File: tb/tb_riscv_checkpoint_monitor.sv
module tb_riscv_checkpoint_monitor;
  localparam int NUM_CHK = 3;
  localparam int IDX_W   = 2;
  localparam int DWIDTH  = 32;
  localparam int CWIDTH  = 32;
  localparam int TIMEOUT = 20;

  logic              CLK = 1'b0;
  logic              RST, LOAD_EN, START, HALT;
  logic [IDX_W-1:0]  LOAD_IDX;
  logic [DWIDTH-1:0] LOAD_INST, LOAD_ANS, NUM_INST, OUTPUT_PORT;
`ifdef CHK_MASK_EN
  logic [DWIDTH-1:0] LOAD_MASK;
`endif
  logic              DONE, PASS;
  logic [1:0]        FAIL_CODE;
  logic [IDX_W-1:0]  FAIL_IDX, CHK_CNT;
  logic [DWIDTH-1:0] FAIL_GOT, FAIL_EXP;
  logic [CWIDTH-1:0] CYCLE;

  riscv_checkpoint_monitor #(
    .NUM_CHK(NUM_CHK), .IDX_W(IDX_W), .DWIDTH(DWIDTH), .CWIDTH(CWIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN), .LOAD_IDX(LOAD_IDX),
    .LOAD_INST(LOAD_INST), .LOAD_ANS(LOAD_ANS),
`ifdef CHK_MASK_EN
    .LOAD_MASK(LOAD_MASK),
`endif
    .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
    .DONE(DONE), .PASS(PASS), .FAIL_CODE(FAIL_CODE), .FAIL_IDX(FAIL_IDX),
    .FAIL_GOT(FAIL_GOT), .FAIL_EXP(FAIL_EXP), .CHK_CNT(CHK_CNT), .CYCLE(CYCLE)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Bench copy of the checkpoint table and the per-cycle stimulus trace.
  logic [31:0] t_inst [NUM_CHK];
  logic [31:0] t_ans  [NUM_CHK];
  logic [31:0] t_mask [NUM_CHK];
  logic [31:0] tr_ni  [$];
  logic [31:0] tr_out [$];
  bit          tr_halt[$];

  // Predicted outcome.
  int          e_end, e_code, e_idx, e_chk, e_cycle;
  bit          e_pass;
  logic [31:0] e_got, e_exp;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int i, input logic [31:0] inst, input logic [31:0] ans,
                           input logic [31:0] mask);
    t_inst[i] = inst;
    t_ans[i]  = ans;
`ifdef CHK_MASK_EN
    t_mask[i] = mask;
`else
    t_mask[i] = '1;
    if (mask == 0) t_mask[i] = '1;
`endif
  endtask

  task automatic push(input logic [31:0] ni, input logic [31:0] out, input bit h);
    tr_ni.push_back(ni);
    tr_out.push_back(out);
    tr_halt.push_back(h);
  endtask

  task automatic clear_trace();
    tr_ni.delete();
    tr_out.delete();
    tr_halt.delete();
  endtask

  // Walk the trace applying the checkpoint rules to predict the outcome.
  task automatic model();
    int p, code, idx;
    p = 0;
    e_end = -1; e_pass = 0; e_code = 0; e_idx = 0; e_got = 0; e_exp = 0;
    for (int k = 0; k < tr_ni.size(); k++) begin
      code = 0;
      idx  = 0;
      if (p < NUM_CHK && tr_ni[k] == t_inst[p]) begin
        if (((tr_out[k] ^ t_ans[p]) & t_mask[p]) == 0) p++;
        else begin code = 1; idx = p; end
      end else if (p < NUM_CHK && tr_ni[k] > t_inst[p]) begin
        code = 2; idx = p;
      end
      if (code == 0 && tr_halt[k] && p < NUM_CHK) begin code = 3; idx = p; end
      if (code != 0) begin
        e_code = code; e_idx = idx; e_got = tr_out[k]; e_exp = t_ans[idx]; e_end = k;
        break;
      end
      if (tr_halt[k]) begin e_pass = 1; e_end = k; break; end
      if (k == TIMEOUT - 1) begin e_end = k; break; end
    end
    e_chk   = p;
    e_cycle = (e_end < 0) ? tr_ni.size() : e_end;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, {DONE, PASS, FAIL_CODE, FAIL_IDX, CHK_CNT, CYCLE}, '0);
    check({tag, "_data"}, {FAIL_GOT, FAIL_EXP}, '0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    check_zero("reset");
    tick();
    RST = 1'b0;
  endtask

  // mode 0: table already loaded; 1: load then START; 2: last write with START.
  task automatic run_trace(input string name, input int mode);
    model();
    if (mode != 0) begin
      for (int i = 0; i < NUM_CHK; i++) begin
        LOAD_EN = 1'b1; LOAD_IDX = IDX_W'(i); LOAD_INST = t_inst[i]; LOAD_ANS = t_ans[i];
`ifdef CHK_MASK_EN
        LOAD_MASK = t_mask[i];
`endif
        if (mode == 2 && i == NUM_CHK - 1) START = 1'b1;
        tick();
      end
      // Out-of-range index must be ignored.
      LOAD_IDX = IDX_W'(NUM_CHK); LOAD_INST = 32'd1; LOAD_ANS = 32'hdead;
      if (mode == 1) tick();
      LOAD_EN = 1'b0;
    end
    if (mode != 2) begin
      START = 1'b1;
      tick();
    end
    START = 1'b0;
    check({name, "_start"}, {DONE, CHK_CNT, CYCLE}, '0);
    for (int k = 0; k < tr_ni.size(); k++) begin
      NUM_INST = tr_ni[k]; OUTPUT_PORT = tr_out[k]; HALT = tr_halt[k];
      tick();
      check({name, "_done_k"}, DONE, e_end >= 0 && k >= e_end);
      if (DONE) break;
    end
    HALT = 1'b0;
    check({name, "_pass"}, PASS, e_pass);
    check({name, "_code"}, FAIL_CODE, e_code);
    check({name, "_idx"}, FAIL_IDX, e_idx);
    check({name, "_got"}, FAIL_GOT, e_got);
    check({name, "_exp"}, FAIL_EXP, e_exp);
    check({name, "_chk"}, CHK_CNT, e_chk);
    check({name, "_cycle"}, CYCLE, e_cycle);
  endtask

  task automatic base_table();
    set_entry(0, 32'd4, 32'h0eec, '1);
    set_entry(1, 32'd6, 32'h0000, '1);
    set_entry(2, 32'd8, 32'h0001, '1);
  endtask

  function automatic logic [31:0] good_out(input logic [31:0] v);
    good_out = (v == 4) ? 32'h0eec : (v == 6) ? 32'h0 : (v == 8) ? 32'h1 : 32'h77;
  endfunction

  task automatic gen_random();
    int v, len;
    logic [31:0] ni, out;
    bit hit;
    v = $urandom_range(1, 3);
    for (int i = 0; i < NUM_CHK; i++) begin
      set_entry(i, v, $urandom_range(0, 15), $urandom);
      v += $urandom_range(1, 3);
    end
    clear_trace();
    ni  = 0;
    len = $urandom_range(6, 24);
    for (int k = 0; k < len; k++) begin
      out = $urandom_range(0, 15);
      hit = 0;
      for (int i = 0; i < NUM_CHK; i++)
        if (t_inst[i] == ni && $urandom_range(0, 7) != 0) begin
          out = (t_ans[i] & t_mask[i]) | ($urandom & ~t_mask[i]);
          hit = 1;
        end
      push(ni, out, (ni > t_inst[NUM_CHK-1]) ? ($urandom_range(0, 2) == 0)
                                              : ($urandom_range(0, 19) == 0));
      if (!hit && $urandom_range(0, 5) == 0) ni += 2;
      else if ($urandom_range(0, 4) != 0) ni += 1;
    end
  endtask

  initial begin
    RST = 1'b1; LOAD_EN = 0; START = 0; HALT = 0; LOAD_IDX = 0;
    LOAD_INST = 0; LOAD_ANS = 0; NUM_INST = 0; OUTPUT_PORT = 0;
`ifdef CHK_MASK_EN
    LOAD_MASK = 0;
`endif
    #1;
    check_zero("por");
    tick();
    RST = 1'b0;

    // Full pass, halt after last checkpoint.
    base_table();
    clear_trace();
    for (int v = 0; v <= 10; v++) push(v, good_out(v), v == 10);
    run_trace("pass", 1);
    check("pass_chk3", CHK_CNT, 3);
    do_reset();

    // Mismatch at entry 1.
    clear_trace();
    for (int v = 0; v <= 8; v++) push(v, (v == 6) ? 32'h5 : good_out(v), 0);
    run_trace("mismatch", 1);
    check("mismatch_got", FAIL_GOT, 32'h5);
    do_reset();

    // Skipped checkpoint: 4 -> 7.
    clear_trace();
    for (int v = 0; v <= 4; v++) push(v, good_out(v), 0);
    push(7, 32'h0, 0);
    push(8, 32'h1, 0);
    run_trace("skip", 2);
    check("skip_code", FAIL_CODE, 2);
    do_reset();

    // Halt together with the match completing the table.
    clear_trace();
    for (int v = 0; v <= 8; v++) push(v, good_out(v), v == 8);
    run_trace("halt_last", 0);
    check("halt_last_pass", PASS, 1);
    do_reset();

    // Halt with entry 2 pending.
    clear_trace();
    for (int v = 0; v <= 6; v++) push(v, good_out(v), v == 6);
    run_trace("halt_early", 0);
    check("halt_early_code", FAIL_CODE, 3);
    do_reset();

    // Timeout with NUM_INST stuck at 0.
    clear_trace();
    for (int k = 0; k < 25; k++) push(0, 32'h0, 0);
    run_trace("tout", 0);
    check("tout_cycle19", CYCLE, 19);
    do_reset();

    // Abort mid-RUN: outputs clear asynchronously.
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int v = 0; v <= 5; v++) begin
      NUM_INST = v; OUTPUT_PORT = good_out(v);
      tick();
    end
    check("abort_pre", {CHK_CNT, CYCLE}, {2'd1, 32'd6});
    #2;
    RST = 1'b1;
    #1;
    check_zero("abort");
    tick();
    RST = 1'b0;

    // Table retained across the abort.
    clear_trace();
    for (int v = 0; v <= 10; v++) push(v, good_out(v), v == 10);
    run_trace("retained", 0);
    do_reset();

    // Masked compare on entry 0.
    set_entry(0, 32'd2, 32'h12ab, 32'h00ff);
    set_entry(1, 32'd5, 32'h1, '1);
    set_entry(2, 32'd9, 32'h2, '1);
    clear_trace();
    for (int v = 0; v <= 3; v++) push(v, (v == 2) ? 32'h99ab : 32'h0, 0);
    run_trace("mask", 1);
`ifdef CHK_MASK_EN
    check("mask_lit", {FAIL_CODE, CHK_CNT}, {2'd0, 2'd1});
`else
    check("mask_lit", {FAIL_CODE, FAIL_GOT}, {2'd1, 32'h99ab});
`endif
    do_reset();

    // Randomised runs.
    for (int r = 0; r < 40; r++) begin
      gen_random();
      run_trace("rand", 1 + (r % 2));
      do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
